// File: rtl/onehot_scan_pkg.sv
// Shared types, default parameters and width helpers for the one-hot scan encoder.
package onehot_scan_pkg;

  typedef enum logic [1:0] {StIdle, StScan, StSum, StParity} state_e;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefDelay = 100_000_000;
  localparam int unsigned DefLedW  = 8;

  // Largest sum is DEPTH rows each contributing the top code WIDTH-1.
  function automatic int unsigned sum_width(int unsigned depth, int unsigned width);
    return $clog2(depth * (width - 1) + 1);
  endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// Control/data bundle of the scan encoder; master drives requests, slave returns display state.
interface onehot_scan_encoder_if
  import onehot_scan_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned LED_W = DefLedW
);

  logic                     PB1;
  logic                     start;
  logic                     mode;
  logic                     wr_en;
  logic [$clog2(DEPTH)-1:0] wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [LED_W-1:0]         led;
  logic                     busy;
  logic                     done;

  modport master (
    output PB1, start, mode, wr_en, wr_addr, wr_data,
    input  led, busy, done
  );

  modport slave (
    input  PB1, start, mode, wr_en, wr_addr, wr_data,
    output led, busy, done
  );

endinterface

// File: rtl/onehot_decode.sv
// Combinational word decoder: strict one-hot check or lowest-set-bit priority encode.
module onehot_decode
  import onehot_scan_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CodeW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] w,
  input  logic             mode,
  output logic             valid,
  output logic [CodeW-1:0] code
);

  localparam int unsigned PopW = $clog2(WIDTH + 1);

  logic [PopW-1:0] ones;
  logic            found;

  always_comb begin
    ones  = '0;
    found = 1'b0;
    code  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) begin
        ones = ones + PopW'(1);
        if (!found) begin
          code  = CodeW'(i);
          found = 1'b1;
        end
      end
    end
    valid = mode ? found : (ones == PopW'(1));
  end

endmodule

// File: rtl/onehot_scan_encoder.sv
// Scans a small table row by row at a slow tick, shows each row's decoded bit index on the LEDs,
// then shows the running sum; a synchronized push button toggles between sum and its parity.
module onehot_scan_encoder
  import onehot_scan_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned DELAY = DefDelay,
  parameter int unsigned LED_W = DefLedW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PB1,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [LED_W-1:0]         led,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CodeW = $clog2(WIDTH);
  localparam int unsigned SumW  = sum_width(DEPTH, WIDTH);
  localparam int unsigned CntW  = $clog2(DELAY);
  localparam logic [CntW-1:0] CntReload = CntW'(DELAY - 1);

  state_e             state_q, state_d;
  logic [AddrW-1:0]   row_q, row_d;
  logic [SumW-1:0]    sum_q, sum_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic               wrapped_q, wrapped_d;
  logic               pb_sync1_q, pb_sync2_q, pb_prev_q;
  logic [WIDTH-1:0]   table_q [DEPTH];

  logic               tick;
  logic               pb_event;
  logic               dec_valid;
  logic [CodeW-1:0]   dec_code;

  onehot_decode #(
    .WIDTH (WIDTH),
    .CodeW (CodeW)
  ) u_decode (
    .w     (table_q[row_q]),
    .mode  (mode_q),
    .valid (dec_valid),
    .code  (dec_code)
  );

  assign tick     = (cnt_q == '0);
  assign pb_event = pb_sync2_q & ~pb_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_sync1_q <= 1'b0;
      pb_sync2_q <= 1'b0;
      pb_prev_q  <= 1'b0;
    end else begin
      pb_sync1_q <= PB1;
      pb_sync2_q <= pb_sync1_q;
      pb_prev_q  <= pb_sync2_q;
    end
  end

  // The row being scanned is read combinationally, so writes are locked out for the whole scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en && (state_q != StScan)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    mode_d    = mode_q;
    wrapped_d = wrapped_q;
    done_d    = 1'b0;

    if (start && (state_q != StScan)) begin
      state_d   = StScan;
      row_d     = '0;
      sum_d     = '0;
      cnt_d     = CntReload;
      mode_d    = mode;
      wrapped_d = 1'b0;
    end else begin
      case (state_q)
        StScan: begin
          if (!tick) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            cnt_d = CntReload;
            // One extra tick after the last row closes the scan.
            if (wrapped_q) begin
              state_d   = StSum;
              led_d     = LED_W'(sum_q);
              done_d    = 1'b1;
              wrapped_d = 1'b0;
            end else begin
              if (dec_valid) begin
                led_d = LED_W'(dec_code);
                sum_d = sum_q + SumW'(dec_code);
              end else begin
                led_d = '1;
              end
              if (row_q == AddrW'(DEPTH - 1)) begin
                row_d     = '0;
                wrapped_d = 1'b1;
              end else begin
                row_d = row_q + AddrW'(1);
              end
            end
          end
        end
        StSum: begin
          if (pb_event) begin
            state_d = StParity;
            led_d   = LED_W'(^sum_q);
          end
        end
        StParity: begin
          if (pb_event) begin
            state_d = StSum;
            led_d   = LED_W'(sum_q);
          end
        end
        StIdle:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == StScan);
  assign done = done_q;

endmodule

// File: doc/onehot_scan_encoder.md
ONEHOT_SCAN_ENCODER -- requirements
Module: onehot_scan_encoder

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- WIDTH, 16, bits per table word.
- DEPTH, 8, number of table rows; power of two and at least 2.
- DELAY, 100_000_000, clock cycles per scan tick; at least 2.
- LED_W, 8, LED output width.
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line, clock and reset first. One clock; reset is asynchronous and active-low.
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- PB1, in, 1, raw push button; asynchronous to clk.
- start, in, 1, one-cycle request to begin a scan.
- mode, in, 1, 0 = strict one-hot, 1 = priority (lowest set bit); sampled when start is accepted.
- wr_en, in, 1, table write strobe.
- wr_addr, in, clog2(DEPTH), table row to write.
- wr_data, in, WIDTH, table word to write.
- led, out, LED_W, display value.
- busy, out, 1, high while in SCAN.
- done, out, 1, one-cycle pulse when the scan completes.

Function
REQ-003 The block SHALL hold a DEPTH x WIDTH table; wr_en SHALL write on the clock edge in IDLE, SUM and PARITY, and SHALL be ignored in SCAN.
REQ-004 States SHALL be IDLE, SCAN, SUM and PARITY.
REQ-005 start SHALL be accepted in IDLE, SUM or PARITY. On acceptance: row=0, sum=0, tick counter loaded with DELAY-1, mode latched, state goes to SCAN. start SHALL be ignored in SCAN.
REQ-006 In SCAN the tick counter SHALL decrement each cycle. The tick SHALL fire when the counter is 0, then the counter reloads DELAY-1. The first tick SHALL occur DELAY cycles after start is accepted.
REQ-007 On each tick in SCAN, the current row word w SHALL be decoded:
- Strict mode: valid only if popcount(w)==1; code = index of that set bit.
- Priority mode: valid if w!=0; code = index of the lowest set bit.
REQ-008 Valid row: led SHALL take code (zero-extended) on the cycle after the tick, and sum += code. Invalid row: led SHALL be all ones and sum is unchanged.
REQ-009 sum SHALL be clog2(DEPTH*(WIDTH-1)+1) bits wide and SHALL never overflow.
REQ-010 After the tick for row DEPTH-1, row SHALL wrap to 0. The next tick SHALL enter SUM, set led = sum truncated to LED_W bits, and pulse done for exactly one cycle.
REQ-011 PB1 SHALL pass through a two-flop synchronizer; a rising edge of the synchronized signal SHALL produce one event.
REQ-012 A PB1 event SHALL have these effects:
- SUM to PARITY: led = {0..., XOR-reduction of the full sum}.
- PARITY to SUM: led = sum.
- IDLE or SCAN: ignored.
REQ-013 When start and a PB1 event occur in the same cycle, start SHALL win.
REQ-014 In SUM and PARITY the tick counter SHALL hold, and led SHALL stay static.

Reset
REQ-015 When rst_n is low, the block SHALL asynchronously set:
- state = IDLE, led = 0, busy = 0, done = 0;
- sum = 0, row = 0, tick counter = 0;
- synchronizer flops = 0, all table rows = 0.
REQ-016 Reset asserted mid-scan SHALL abort the scan with no done pulse. After deassertion the block SHALL wait in IDLE for start.

Structure
REQ-017 A package onehot_scan_pkg SHALL hold the state enum, the default parameter values and the function computing the sum width.
REQ-018 A combinational sub-module onehot_decode (WIDTH; inputs w and mode; outputs valid and code) SHALL perform the popcount and priority encode.

Verification
Common bench setup: DELAY=4. Table rows 0..7 loaded with 0000, 8800, 0100, 8000, 0001, 0800, 8110, 0080 hex.
REQ-019 Strict scan: start with mode=0. led SHALL show FF, FF, 08, 0F, 00, 0B, FF, 07 at 4-cycle spacing. SUM SHALL then give led=0x29 and one done pulse.
REQ-020 Priority scan: same table, mode=1. Row codes SHALL be FF, 0B, 08, 0F, 00, 0B, 04, 07. SUM SHALL give led=0x38.
REQ-021 Parity toggling:
- After REQ-019, a PB1 pulse of 3 or more cycles SHALL give led=0x01; a second pulse SHALL give led=0x29.
- PB1 pulsed during SCAN SHALL leave led unchanged.
REQ-022 Write gating: wr_en during SCAN SHALL not alter the table, confirmed by a rescan giving the same sum. wr_en in SUM followed by start SHALL use the new data.
REQ-023 Reset mid-scan: asserting rst_n low at row 3 SHALL give led=0, busy=0 and no done pulse. A subsequent start SHALL reproduce REQ-019 exactly.
REQ-024 Start priority: start and a PB1 edge in the same SUM cycle SHALL enter SCAN, with busy=1 on the next cycle.
